// File: rtl/bit_serial_multiplier_array.sv
// bit_serial_multiplier_array
//
// W x W bit-serial multiplier. Both operands stream in LSB-first, one bit
// per cycle; the exact 2W-bit product streams out LSB-first with a fixed
// latency of one cycle. Works in unsigned or two's complement mode,
// selected per operation, and accepts back-to-back operations with no
// bubble.
//
// Datapath: a linear array of W carry-save slices plus one guard slice.
// Slice i keeps the operand bits x[i]/y[i] (captured at cycle i), a sum bit
// shifted down from slice i+1, its own weight-2 carry and the weight-4
// carry from slice i-1. Each cycle a 5-to-3 counter per slice adds the new
// partial-product bits to that state. The accumulator shifts right by one
// position per cycle, so slice 0 produces the next product bit.
//
// In cycle k, slice i adds:
//   i <  k : x[k]&y[i] + y[k]&x[i]   (cross terms for the new bit pair)
//   i == k : x[k]&y[k]               (diagonal term)
//   i >  k : nothing yet
// For k >= W the operands are extended with their captured sign bit in
// signed mode, or with 0 in unsigned mode. Terms of weight 2^(2W) or more
// are never formed, so the result is the product modulo 2^(2W).
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset, priority over start
//   start       request a new multiply; x_bit/y_bit carry bit 0 this cycle
//   signed_mode 1 = two's complement operands (sampled at accept only)
//   x_bit       multiplicand bit, LSB-first
//   y_bit       multiplier bit, LSB-first
//   busy        operation in progress (cycles 1..2W)
//   p_bit       product bit, LSB-first
//   p_valid     p_bit valid this cycle
//   p_first     p_bit is product bit 0
//   p_last      p_bit is product bit 2W-1
module bit_serial_multiplier_array #(
  parameter int W         = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic signed_mode,
  input  logic x_bit,
  input  logic y_bit,
  output logic busy,
  output logic p_bit,
  output logic p_valid,
  output logic p_first,
  output logic p_last
);

  localparam int            CW       = $clog2(2 * W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * W);
  localparam logic [CW-1:0] PRE_LAST = CW'(2 * W - 1);
  localparam logic [CW-1:0] W_CNT    = CW'(W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Control state
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q;

  // Slice state: operand bits, shifted sum, weight-2 and weight-4 carries.
  // c2_q[i] is the carry into slice i from slice i-1; slice 0 receives none.
  logic [W-1:0] x_q, y_q;
  logic [W-1:0] s_q, s_d;
  logic [W:0]   c1_q, c1_d;
  logic [W:1]   c2_q, c2_d;

  // Registered outputs
  logic busy_q, p_bit_q, p_valid_q, p_first_q, p_last_q;

  // Combinational control and datapath
  logic          accept, active, in_op;
  logic          x_cur, y_cur;
  logic [CW-1:0] k;
  logic [W-1:0]  pa, pb;
  logic [W-1:0]  s_m;
  logic [W:0]    c1_m, c2_m;
  logic [W:0]    sum_v;
  logic [2:0]    cnt3;

  // A new operation may start from IDLE or overlap the last output bit.
  assign accept = start && ((state_q == IDLE) || p_last_q);
  // A bit pair is processed in the accept cycle and in cycles 1..2W-1.
  assign active = accept || ((state_q == RUN) && (cnt_q != LAST_CNT));
  // Index of the operand bit pair in flight this cycle.
  assign k      = accept ? '0 : cnt_q;
  assign in_op  = (k < W_CNT);

  // Beyond bit W-1 the operands are sign- or zero-extended internally.
  // mode_q is stale in the accept cycle, but k=0 never uses the extension.
  assign x_cur  = in_op ? x_bit : (mode_q & x_q[W-1]);
  assign y_cur  = in_op ? y_bit : (mode_q & y_q[W-1]);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    pa    = '0;
    pb    = '0;
    sum_v = '0;
    c1_d  = '0;
    c2_d  = '0;
    cnt3  = '0;

    // The accept cycle sees a cleared array, so leftover state from the
    // previous product never leaks into the new one.
    s_m   = accept ? '0 : s_q;
    c1_m  = accept ? '0 : c1_q;
    c2_m  = accept ? '0 : {c2_q, 1'b0};

    for (int i = 0; i < W; i++) begin
      if (k > CW'(i)) begin
        pa[i] = x_cur & y_q[i];
        pb[i] = y_cur & x_q[i];
      end else if (k == CW'(i)) begin
        pa[i] = x_cur & y_cur;
      end
      // 5-to-3 counter: five weight-1 inputs -> sum, weight-2, weight-4.
      cnt3 = 3'(pa[i]) + 3'(pb[i]) + 3'(s_m[i]) + 3'(c1_m[i]) + 3'(c2_m[i]);
      sum_v[i]    = cnt3[0];
      c1_d[i]     = cnt3[1];
      c2_d[i + 1] = cnt3[2];
    end

    // Guard slice above the operand slices: only two carry inputs arrive
    // here, so a half adder absorbs them and nothing spills further up.
    sum_v[W] = c1_m[W] ^ c2_m[W];
    c1_d[W]  = c1_m[W] & c2_m[W];
  end

  // Sums move down one slice per cycle; slice 0's sum is the product bit.
  assign s_d = sum_v[W:1];

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the slice registers are few and are cleared by reset as well,
      // so a post-reset state is fully defined, not just the control path.
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      s_q       <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      busy_q    <= 1'b0;
      p_bit_q   <= 1'b0;
      p_valid_q <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      // Output framing: bit k of the product leaves one cycle after it is
      // formed, so busy and p_valid both cover cycles 1..2W.
      busy_q    <= active;
      p_valid_q <= active;
      p_bit_q   <= active & sum_v[0];
      p_first_q <= accept;
      p_last_q  <= active && (k == PRE_LAST);

      if (accept) begin
        state_q <= RUN;
        cnt_q   <= CW'(1);
        mode_q  <= SIGNED_EN & signed_mode;
      end else if (state_q == RUN) begin
        if (cnt_q == LAST_CNT) begin
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      if (active) begin
        s_q  <= s_d;
        c1_q <= c1_d;
        c2_q <= c2_d;
        for (int i = 0; i < W; i++) begin
          if (k == CW'(i)) begin
            x_q[i] <= x_bit;
            y_q[i] <= y_bit;
          end
        end
      end
    end
  end

  assign busy    = busy_q;
  assign p_bit   = p_bit_q;
  assign p_valid = p_valid_q;
  assign p_first = p_first_q;
  assign p_last  = p_last_q;

endmodule

// File: tb/tb_bit_serial_multiplier_array.sv
// tb_bit_serial_multiplier_array
//
// Directed bench for bit_serial_multiplier_array. Three instances:
//   dut 0 : W=8, SIGNED_EN=1  (main function, back-to-back, ignored start,
//           reset mid-operation)
//   dut 1 : W=2, SIGNED_EN=1  (smallest width, 4-cycle frame)
//   dut 2 : W=8, SIGNED_EN=0  (signed_mode must be ignored)
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same point, well away from the next edge. Operand bits
// past W-1 are random, since they are don't-care.
module tb_bit_serial_multiplier_array;

  logic       clk;
  logic       reset;
  logic [2:0] st, sm, xi, yi;
  logic [2:0] bz, pb, pv, pf, pl;

  int total;
  int bad;

  bit_serial_multiplier_array #(.W(8), .SIGNED_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(st[0]), .signed_mode(sm[0]),
    .x_bit(xi[0]), .y_bit(yi[0]), .busy(bz[0]), .p_bit(pb[0]),
    .p_valid(pv[0]), .p_first(pf[0]), .p_last(pl[0])
  );

  bit_serial_multiplier_array #(.W(2), .SIGNED_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(st[1]), .signed_mode(sm[1]),
    .x_bit(xi[1]), .y_bit(yi[1]), .busy(bz[1]), .p_bit(pb[1]),
    .p_valid(pv[1]), .p_first(pf[1]), .p_last(pl[1])
  );

  bit_serial_multiplier_array #(.W(8), .SIGNED_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .start(st[2]), .signed_mode(sm[2]),
    .x_bit(xi[2]), .y_bit(yi[2]), .busy(bz[2]), .p_bit(pb[2]),
    .p_valid(pv[2]), .p_first(pf[2]), .p_last(pl[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic s, input logic m, input logic xb, input logic yb);
    st[d] = s;
    sm[d] = m;
    xi[d] = xb;
    yi[d] = yb;
  endtask

  // One cycle with inputs quiet; every output of dut d must be 0.
  task automatic idle_check(input int d, input string tag);
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 1'b0, 1'b0);
    chk(tag, {59'd0, bz[d], pv[d], pf[d], pl[d], pb[d]}, 64'd0);
  endtask

  // Runs one multiply on dut d of width w. If started is set, the accept
  // cycle was already driven by the previous call (back-to-back). If chain
  // is set, the next operation's start and bit 0 are driven at cycle 2w.
  // Start is also pulsed at cycles ign1/ign2 (0 = none); it must be ignored.
  task automatic run_op(input int d, input int w, input logic m,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp_p, input string tag,
                        input bit started, input bit chain, input logic nm,
                        input logic [31:0] nx, input logic [31:0] ny,
                        input int ign1, input int ign2);
    logic [63:0] got;
    logic        xb, yb;
    got = '0;
    if (!started) begin
      @(posedge clk);
      #1;
      drive(d, 1'b1, m, x[0], y[0]);
    end
    for (int c = 1; c <= 2 * w; c++) begin
      @(posedge clk);
      #1;
      xb = (c < w) ? x[c] : 1'($urandom);
      yb = (c < w) ? y[c] : 1'($urandom);
      if (chain && (c == 2 * w)) begin
        drive(d, 1'b1, nm, nx[0], ny[0]);
      end else begin
        drive(d, (c == ign1) || (c == ign2), 1'($urandom), xb, yb);
      end
      chk($sformatf("%s_frame_c%0d", tag, c),
          {60'd0, bz[d], pv[d], pf[d], pl[d]},
          {60'd0, 1'b1, 1'b1, (c == 1), (c == 2 * w)});
      got[c - 1] = pb[d];
    end
    chk($sformatf("%s_product", tag), got, exp_p);
  endtask

  initial begin
    logic [31:0] xr, yr;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    st = '0; sm = '0; xi = '0; yi = '0;

    // Reset state of all three instances
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_state_dut%0d", d),
          {59'd0, bz[d], pv[d], pf[d], pl[d], pb[d]}, 64'd0);
    end
    reset = 1'b0;
    idle_check(0, "idle_after_reset");

    // Unsigned all-ones squared: 0xFF*0xFF = 0xFE01
    run_op(0, 8, 1'b0, 32'hFF, 32'hFF, 64'hFE01, "t1_ff_ff", 0, 0, 0, 0, 0, 0, 0);
    idle_check(0, "t1_idle");

    // Signed most-negative squared and sign handling
    run_op(0, 8, 1'b1, 32'h80, 32'h80, 64'h4000, "t2_s_80_80", 0, 0, 0, 0, 0, 0, 0);
    idle_check(0, "t2a_idle");
    run_op(0, 8, 1'b1, 32'hFF, 32'h01, 64'hFFFF, "t2_s_ff_01", 0, 0, 0, 0, 0, 0, 0);
    idle_check(0, "t2b_idle");
    run_op(0, 8, 1'b0, 32'hFF, 32'h01, 64'h00FF, "t2_u_ff_01", 0, 0, 0, 0, 0, 0, 0);
    idle_check(0, "t2c_idle");
    // -128 * 127 = -16256 = 0xC080
    run_op(0, 8, 1'b1, 32'h80, 32'h7F, 64'hC080, "t2_s_80_7f", 0, 0, 0, 0, 0, 0, 0);
    idle_check(0, "t2d_idle");

    // Back-to-back: 3*5 then 7*9 with no gap
    run_op(0, 8, 1'b0, 32'd3, 32'd5, 64'h000F, "t3_first", 0, 1, 1'b0, 32'd7, 32'd9, 0, 0);
    run_op(0, 8, 1'b0, 32'd7, 32'd9, 64'h003F, "t3_second", 1, 0, 0, 0, 0, 0, 0);
    idle_check(0, "t3_idle");

    // start pulsed at cycles 3 and 9 of a running op must be ignored
    run_op(0, 8, 1'b0, 32'h12, 32'h34, 64'h03A8, "t4_ignore", 0, 0, 0, 0, 0, 3, 9);
    idle_check(0, "t4_idle");

    // Reset at cycle 5 of 0xAA*0x55
    xr = 32'hAA;
    yr = 32'h55;
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, xr[0], yr[0]);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, xr[c], yr[c]);
      if (c == 5) reset = 1'b1;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_reset_outputs", {59'd0, bz[0], pv[0], pf[0], pl[0], pb[0]}, 64'd0);
    idle_check(0, "t5_no_resume");
    run_op(0, 8, 1'b0, 32'h02, 32'h03, 64'h0006, "t5_after_reset", 0, 0, 0, 0, 0, 0, 0);
    idle_check(0, "t5_idle");

    // W=2: signed -2*-2 = 4, unsigned 3*3 = 9, signed -1*-1 = 1
    run_op(1, 2, 1'b1, 32'h2, 32'h2, 64'h4, "t6_w2_s_2_2", 0, 0, 0, 0, 0, 0, 0);
    idle_check(1, "t6a_idle");
    run_op(1, 2, 1'b0, 32'h3, 32'h3, 64'h9, "t6_w2_u_3_3", 0, 0, 0, 0, 0, 0, 0);
    idle_check(1, "t6b_idle");
    run_op(1, 2, 1'b1, 32'h3, 32'h3, 64'h1, "t6_w2_s_3_3", 0, 0, 0, 0, 0, 0, 0);
    idle_check(1, "t6c_idle");

    // SIGNED_EN=0: signed_mode=1 is ignored, 0x80*0x02 = 0x0100
    run_op(2, 8, 1'b1, 32'h80, 32'h02, 64'h0100, "t6_nosign_80_02", 0, 0, 0, 0, 0, 0, 0);
    idle_check(2, "t6d_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_multiplier_array.md
Name: bit_serial_multiplier_array

Overview:
Parametrised W-bit by W-bit bit-serial multiplier built as a linear array of carry-save slices, each with a 5-to-3 counter and local x/y/carry registers.
Both operands stream in LSB-first, one bit per cycle each. The exact 2W-bit product streams out LSB-first.
Adds a control FSM, start/busy handshake, output framing, runtime unsigned/signed (two's complement) mode and back-to-back operation.
Sits between the serial operand shifters and the serial accumulator in the datapath.

Parameters:
W, 8, operand width in bits; legal range 2..32; product width is 2W.
SIGNED_EN, 1, 1 = honour signed_mode; 0 = signed_mode ignored and treated as 0 (signed logic may be optimised away).

Ports:
clk  input  1  rising-edge clock, the only clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request a new multiply; x_bit/y_bit carry bit 0 in this same cycle.
signed_mode  input  1  sampled only in the accept cycle; 1 = two's complement operands.
x_bit  input  1  multiplicand bit, LSB-first.
y_bit  input  1  multiplier bit, LSB-first.
busy  output  1  operation in progress.
p_bit  output  1  product bit, LSB-first.
p_valid  output  1  p_bit is valid this cycle.
p_first  output  1  p_bit is product bit 0.
p_last  output  1  p_bit is product bit 2W-1.

Behaviour:
- Reset: at the clk edge where reset=1, every output register goes to 0 and the FSM goes to IDLE. Reset clears all slice registers and the bit counter. Reset has priority over start.
- Reset mid-operation: the partial product is discarded. No further p_valid until a new accepted start.
- Accept rule: start is accepted when state=IDLE, or in the cycle where p_last=1 (pipelined back-to-back). start in any other cycle is ignored, with no side effects.
- Cycle numbering: the accept cycle is cycle 0.
- Input sampling: x[k] and y[k] are sampled at cycles k=0..W-1. x_bit and y_bit are don't-care at cycles W..2W-1.
- Operand extension: for k>=W, the array uses internal extension bits. Signed mode uses the sign bit captured at cycle W-1; unsigned mode uses 0.
- Mode capture: signed_mode is registered at accept and held for the whole operation.
- Output timing: p[k] appears on p_bit with p_valid=1 at cycle k+1, for k=0..2W-1. This is a fixed latency of 1 with no gaps.
- Framing: p_first=1 only at cycle 1. p_last=1 only at cycle 2W.
- Outside a frame: p_valid, p_first, p_last and p_bit are all 0.
- busy: 1 from cycle 1 through cycle 2W inclusive. If a back-to-back start is accepted at cycle 2W, busy stays 1 with no bubble.
- FSM: IDLE -> RUN on accept.
- Bit counter: ceil(log2(2W+1)) bits, counting 1..2W; it is reset to 1 on every accept.
- RUN -> RUN on a back-to-back accept at count=2W. RUN -> IDLE at count=2W with no accept.
- Arithmetic: the result is the exact 2W-bit product, mod 2^(2W). The signed result equals the two's complement product of the W-bit operands. No overflow is possible.
- Slice state: the carry-save feedback and carry registers of every slice clear at the accept edge, so consecutive products never interact.
- Boundary: W=2 must work, giving a 4-cycle frame.
- Boundary: the maximum-magnitude cases must be exact: unsigned all-ones squared, and signed most-negative squared.

Test Plan:
1. W=8, unsigned, x=0xFF, y=0xFF -> p=0xFE01 serialised LSB-first over cycles 1..16; p_first at cycle 1, p_last at cycle 16, busy cycles 1..16.
2. W=8, signed, x=0x80, y=0x80 (-128*-128) -> p=0x4000. Then signed x=0xFF, y=0x01 (-1*1) -> p=0xFFFF. Then unsigned x=0xFF, y=0x01 -> p=0x00FF.
3. Back-to-back: assert start at cycle 16 of the first product (3*5), carrying bit 0 of the second product (7*9). Required: p=0x000F then p=0x003F contiguous, with p_valid high for 32 cycles and busy never dropping.
4. start pulsed at cycles 3 and 9 of a running op (x=0x12, y=0x34) -> ignored; p=0x03A8 unchanged, single frame.
5. reset at cycle 5 of a 0xAA*0x55 op -> next cycle all outputs 0 and state IDLE; a new 0x02*0x03 op then yields p=0x0006.
6. W=2 instance, signed, x=2'b10, y=2'b10 -> p=4'b0100 over cycles 1..4. SIGNED_EN=0 with signed_mode=1, W=8, x=0x80, y=0x02 -> p=0x0100.
